freq_calc: RTL and testbench

- Consumer side of the reciprocal-counting frequency meter's measurement interface.
- Watches the measurement counts `a` (reference-clock ticks in the gate window) and `b` (wave edges in the same window), plus their `safe` flag.
- Captures each new, stable count pair and computes `freq_hz = floor(b * REF_HZ / a)` with a sequential restoring divider.
- Presents the result with a one-cycle valid strobe to the display/readout logic.

---
 rtl/freq_calc.sv | 121 ++++++++++++
 tb/tb_freq_calc.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/freq_calc.sv
// freq_calc: reciprocal frequency readout, freq_hz = floor(b * REF_HZ / a),
// captured from stable count pairs and divided with a 64-step restoring divider.
module freq_calc #(
    parameter longint unsigned REF_HZ = 100_000_000,
    parameter int CNT_W = 32,
    parameter int OUT_W = 32,
    parameter int STABLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             safe,
    input  logic [CNT_W-1:0] a,
    input  logic [CNT_W-1:0] b,
    output logic [OUT_W-1:0] freq_hz,
    output logic             freq_valid,
    output logic             err,
    output logic             sat,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state, state_n;
    logic s1, safe_s;
    logic [CNT_W-1:0] a_d, b_d, a_last, b_last, a_q, b_q;
    logic [3:0] cnt;
    logic err_n;
    logic [63:0] num, quo;
    logic [CNT_W:0] rem;
    logic [CNT_W+1:0] trial;
    logic [5:0] iter;
    logic qual, capture, ge;

    // a pair is trusted only once it is settled and flagged safe, and is new
    assign qual = safe_s && a == a_d && b == b_d && (a != a_last || b != b_last);
    assign capture = state == IDLE && cnt == 4'(STABLE_CYC);
    assign trial = {rem, num[63]};
    assign ge = trial >= (CNT_W+2)'(a_q);
    assign busy = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = capture ? (a == '0 ? DONE : MUL) : IDLE;
            MUL: state_n = DIV;
            DIV: state_n = iter == 6'd0 ? DONE : DIV;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            safe_s <= 1'b0;
            a_d <= '0;
            b_d <= '0;
            a_last <= '0;
            b_last <= '0;
            a_q <= '0;
            b_q <= '0;
            cnt <= '0;
            err_n <= 1'b0;
        end else begin
            s1 <= safe;
            safe_s <= s1;
            a_d <= a;
            b_d <= b;
            if (capture) begin
                a_last <= a;
                b_last <= b;
                a_q <= a;
                b_q <= b;
                cnt <= '0;
                err_n <= a == '0;
            end else if (!qual) begin
                cnt <= '0;
            end else if (cnt != 4'(STABLE_CYC)) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num <= '0;
            quo <= '0;
            rem <= '0;
            iter <= '0;
            freq_hz <= '0;
            freq_valid <= 1'b0;
            err <= 1'b0;
            sat <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            case (state)
                MUL: begin
                    num <= 64'(b_q) * REF_HZ;
                    rem <= '0;
                    iter <= 6'd63;
                end
                DIV: begin
                    num <= {num[62:0], 1'b0};
                    rem <= ge ? (CNT_W+1)'(trial - (CNT_W+2)'(a_q)) : trial[CNT_W:0];
                    quo <= {quo[62:0], ge};
                    iter <= iter - 6'd1;
                end
                DONE: begin
                    freq_valid <= 1'b1;
                    freq_hz <= err_n ? '0 : (|quo[63:OUT_W] ? '1 : quo[OUT_W-1:0]);
                    err <= err_n;
                    sat <= !err_n && |quo[63:OUT_W];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_freq_calc.sv
// tb_freq_calc: directed and random count pairs checked against an arithmetic model
// of the expected frequency, flags and strobe latency.
module tb_freq_calc;
    localparam longint unsigned REF = 100_000_000;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst, safe;
    logic [31:0] a, b;
    logic [31:0] freq_hz;
    logic freq_valid, err, sat, busy;
    int total = 0;
    int bad = 0;

    freq_calc #(.REF_HZ(REF), .CNT_W(32), .OUT_W(32), .STABLE_CYC(S)) dut (
        .clk(clk), .rst(rst), .safe(safe), .a(a), .b(b),
        .freq_hz(freq_hz), .freq_valid(freq_valid), .err(err), .sat(sat), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [31:0] ta, input logic [31:0] tb_,
                                  output logic [31:0] f, output logic e, output logic s);
        longint unsigned qa, qb, q;
        qa = ta;
        qb = tb_;
        e = ta == 0;
        s = 1'b0;
        f = '0;
        if (!e) begin
            q = qb * REF / qa;
            s = q > 64'hFFFF_FFFF;
            f = s ? 32'hFFFF_FFFF : q[31:0];
        end
    endfunction

    task automatic expect_result(input string tag, input int exp_lat, input logic [31:0] ef,
                                 input logic ee, input logic es);
        int lat = 0;
        int extra = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 40 && !ee) chk({tag, "_busy"}, busy, 1);
        end while (!freq_valid && lat < 300);
        chk({tag, "_valid"}, freq_valid, 1);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_freq"}, freq_hz, ef);
        chk({tag, "_err"}, err, ee);
        chk({tag, "_sat"}, sat, es);
        repeat (80) begin
            @(negedge clk);
            if (freq_valid) extra++;
        end
        chk({tag, "_extra"}, extra, 0);
    endtask

    task automatic drive(input logic [31:0] ta, input logic [31:0] tb_, input string tag);
        logic [31:0] f;
        logic e, s;
        model(ta, tb_, f, e, s);
        @(negedge clk);
        a = ta;
        b = tb_;
        expect_result(tag, e ? S + 3 : S + 68, f, e, s);
    endtask

    task automatic no_valid(input string tag, input int cycles);
        int n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (freq_valid) n++;
        end
        chk(tag, n, 0);
    endtask

    initial begin
        logic [31:0] f, ta, tb_;
        logic e, s;
        int n;
        rst = 1'b1;
        safe = 1'b1;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        chk("rst_freq", freq_hz, 0);
        chk("rst_valid", freq_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_sat", sat, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        no_valid("zero_pair_idle", 20);

        drive(32'd100_000_000, 32'd1000, "khz");
        drive(32'd3, 32'd1, "trunc");
        @(negedge clk);
        safe = 1'b0;
        repeat (5) @(negedge clk);
        safe = 1'b1;
        a = 32'd3;
        b = 32'd1;
        no_valid("same_pair", 100);

        drive(32'd0, 32'd5, "a_zero");
        drive(32'd50_000_000, 32'd7, "after_err");
        drive(32'd1, 32'hFFFF_FFFF, "sat");

        @(negedge clk);
        safe = 1'b0;
        repeat (5) @(negedge clk);
        a = 32'd200;
        b = 32'd2;
        no_valid("safe_low", 30);
        @(negedge clk);
        safe = 1'b1;
        model(32'd200, 32'd2, f, e, s);
        expect_result("safe_rise", S + 69, f, e, s);

        a = 32'd777;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (freq_valid) n++;
            b = i[0] ? 32'd6 : 32'd5;
        end
        chk("toggle", n, 0);
        model(32'd777, 32'd6, f, e, s);
        expect_result("toggle_end", S + 68, f, e, s);

        @(negedge clk);
        a = 32'd12345;
        b = 32'd678;
        repeat (S + 36) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_freq", freq_hz, 0);
        chk("abort_err", err, 0);
        chk("abort_sat", sat, 0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", freq_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        model(32'd12345, 32'd678, f, e, s);
        expect_result("recapture", S + 69, f, e, s);

        for (int i = 0; i < 8; i++) begin
            do begin
                ta = $urandom_range(0, 9) == 0 ? 32'd0 :
                     ($urandom_range(0, 1) == 1 ? $urandom_range(1, 5000) : $urandom);
                tb_ = $urandom_range(0, 1) == 1 ? $urandom_range(0, 100_000) : $urandom;
            end while (ta == a && tb_ == b);
            drive(ta, tb_, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
